// File: rtl/score_bcd_if.sv
// Request/result bundle between the scoreboard controller and the BCD converter.
interface score_bcd_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIGITS    = 3,
   parameter int unsigned WKT_WIDTH = 4
) ();

   logic                  start;
   logic [WIDTH-1:0]      binary_runs;
   logic [WKT_WIDTH-1:0]  binary_wickets;
   logic                  inning_over;
   logic                  game_over;
   logic                  winner;
   logic [4*DIGITS-1:0]   run_digits;
   logic [3:0]            wickets;
   logic                  busy;
   logic                  done;
   logic                  overflow;

   // Controller side: issues requests, consumes display codes.
   modport master (
      output start, binary_runs, binary_wickets, inning_over, game_over, winner,
      input  run_digits, wickets, busy, done, overflow
   );

   // Converter side.
   modport slave (
      input  start, binary_runs, binary_wickets, inning_over, game_over, winner,
      output run_digits, wickets, busy, done, overflow
   );

endinterface

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter for the scoreboard run/wicket display.
// Glyph requests (game over / inning over) bypass the shifter and finish in one cycle.
module score_bcd_converter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIGITS    = 3,
   parameter int unsigned WKT_WIDTH = 4
) (
   input logic        clk,
   input logic        reset_n,
   score_bcd_if.slave bus
);

   // One spare digit above ceil(WIDTH/3) so the largest run total never truncates.
   localparam int unsigned ScratchDigits = (WIDTH + 2) / 3 + 1;
   localparam int unsigned ScratchBits   = 4 * ScratchDigits;
   localparam int unsigned PadDigits     = (ScratchDigits > DIGITS) ? ScratchDigits : DIGITS;
   localparam int unsigned PadBits       = 4 * PadDigits;
   localparam int unsigned CntWidth      = $clog2(WIDTH + 1);

   // Display glyph codes understood by the downstream 7-segment decoder.
   localparam logic [3:0] GlyphBlank    = 4'hA;
   localparam logic [3:0] GlyphApostA   = 4'hC;
   localparam logic [3:0] GlyphI        = 4'hD;
   localparam logic [3:0] GlyphApostB   = 4'hE;
   localparam logic [3:0] GlyphT        = 4'hF;

   typedef enum logic [1:0] {StIdle, StShift, StDone} stateE;

   stateE                 stateQ, stateD;
   logic [WIDTH-1:0]      runsQ;
   logic [WKT_WIDTH-1:0]  wktQ;
   logic                  gameQ;
   logic                  inningQ;
   logic                  winnerQ;
   logic [CntWidth-1:0]   iterQ;
   logic [ScratchBits-1:0] bcdQ, bcdD;
   logic [3:0]            nib;
   logic                  carry;

   logic [4*DIGITS-1:0]   digitsQ, digitsNext;
   logic [3:0]            wicketsQ, wicketsNext;
   logic                  overflowQ, overflowNext;
   logic                  doneQ;

   logic [PadBits-1:0]    bcdPad;
   logic [4*DIGITS-1:0]   glyphDigits;
   logic [7:0]            wktExt;
   logic [7:0]            wktMod;
   logic                  runsTooBig;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state: glyph requests skip the shifter; numeric path runs WIDTH iterations.
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle: begin
            if (bus.start) begin
               stateD = (bus.game_over || bus.inning_over) ? StDone : StShift;
            end
         end
         StShift: begin
            if (iterQ <= CntWidth'(1)) begin
               stateD = StDone;
            end
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   // One double-dabble step: add 3 to nibbles >= 5, then shift the next run bit in.
   always_comb begin
      bcdD  = bcdQ;
      nib   = 4'h0;
      carry = runsQ[WIDTH-1];
      for (int k = 0; k < ScratchDigits; k++) begin
         nib = bcdQ[4*k +: 4];
         if (nib >= 4'd5) begin
            nib = nib + 4'd3;
         end
         bcdD[4*k +: 4] = {nib[2:0], carry};
         carry          = nib[3];
      end
   end

   // Outputs: busy from state, plus the result that DONE will register.
   always_comb begin
      bus.busy = (stateQ != StIdle);

      bcdPad     = PadBits'(bcdQ);
      runsTooBig = |(bcdPad >> (4 * DIGITS));

      wktExt = 8'(wktQ);
      wktMod = wktExt % 8'd10;

      glyphDigits                      = {DIGITS{GlyphBlank}};
      glyphDigits[4*(DIGITS-1) +: 4]   = gameQ ? GlyphT : GlyphApostA;
      glyphDigits[4*(DIGITS-2) +: 4]   = gameQ ? 4'h0 : GlyphI;
      glyphDigits[3:0]                 = gameQ ? (winnerQ ? 4'h2 : 4'h1) : 4'h0;

      if (gameQ) begin
         digitsNext   = glyphDigits;
         wicketsNext  = 4'h0;
         overflowNext = 1'b0;
      end else if (inningQ) begin
         digitsNext   = glyphDigits;
         wicketsNext  = GlyphApostB;
         overflowNext = 1'b0;
      end else begin
         // Saturate to all nines when the total does not fit the display.
         digitsNext   = runsTooBig ? {DIGITS{4'h9}} : bcdPad[4*DIGITS-1:0];
         wicketsNext  = wktMod[3:0];
         overflowNext = runsTooBig;
      end
   end

   // Datapath: latch the request, run the shifter, register results in DONE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         runsQ     <= '0;
         wktQ      <= '0;
         gameQ     <= 1'b0;
         inningQ   <= 1'b0;
         winnerQ   <= 1'b0;
         iterQ     <= '0;
         bcdQ      <= '0;
         digitsQ   <= '0;
         wicketsQ  <= '0;
         overflowQ <= 1'b0;
         doneQ     <= 1'b0;
      end else begin
         doneQ <= 1'b0;
         unique case (stateQ)
            StIdle: begin
               if (bus.start) begin
                  runsQ   <= bus.binary_runs;
                  wktQ    <= bus.binary_wickets;
                  gameQ   <= bus.game_over;
                  inningQ <= bus.inning_over;
                  winnerQ <= bus.winner;
                  bcdQ    <= '0;
                  iterQ   <= (bus.game_over || bus.inning_over) ? '0 : CntWidth'(WIDTH);
               end
            end
            StShift: begin
               bcdQ  <= bcdD;
               runsQ <= {runsQ[WIDTH-2:0], 1'b0};
               iterQ <= iterQ - CntWidth'(1);
            end
            StDone: begin
               digitsQ   <= digitsNext;
               wicketsQ  <= wicketsNext;
               overflowQ <= overflowNext;
               doneQ     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.run_digits = digitsQ;
   assign bus.wickets    = wicketsQ;
   assign bus.overflow   = overflowQ;
   assign bus.done       = doneQ;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Randomized bench for score_bcd_converter: two instances (WIDTH 8 and 10), decimal reference model.
module tb_score_bcd_converter;

   logic        clk;
   logic        resetN;
   bit          dutSel;
   logic        startDrv;
   logic [9:0]  runsDrv;
   logic [3:0]  wktDrv;
   logic        ioDrv;
   logic        goDrv;
   logic        winDrv;

   int unsigned nChecks = 0;
   int unsigned nFails  = 0;

   score_bcd_if #(.WIDTH(8),  .DIGITS(3), .WKT_WIDTH(4)) bus8 ();
   score_bcd_if #(.WIDTH(10), .DIGITS(3), .WKT_WIDTH(4)) bus10 ();

   score_bcd_converter #(.WIDTH(8), .DIGITS(3), .WKT_WIDTH(4)) u_dut8 (
      .clk     (clk),
      .reset_n (resetN),
      .bus     (bus8)
   );

   score_bcd_converter #(.WIDTH(10), .DIGITS(3), .WKT_WIDTH(4)) u_dut10 (
      .clk     (clk),
      .reset_n (resetN),
      .bus     (bus10)
   );

   assign bus8.start           = startDrv && !dutSel;
   assign bus8.binary_runs     = runsDrv[7:0];
   assign bus8.binary_wickets  = wktDrv;
   assign bus8.inning_over     = ioDrv;
   assign bus8.game_over       = goDrv;
   assign bus8.winner          = winDrv;
   assign bus10.start          = startDrv && dutSel;
   assign bus10.binary_runs    = runsDrv;
   assign bus10.binary_wickets = wktDrv;
   assign bus10.inning_over    = ioDrv;
   assign bus10.game_over      = goDrv;
   assign bus10.winner         = winDrv;

   logic [11:0] obsDigits;
   logic [3:0]  obsWkt;
   logic        obsBusy, obsDone, obsOvf;
   assign obsDigits = dutSel ? bus10.run_digits : bus8.run_digits;
   assign obsWkt    = dutSel ? bus10.wickets    : bus8.wickets;
   assign obsBusy   = dutSel ? bus10.busy       : bus8.busy;
   assign obsDone   = dutSel ? bus10.done       : bus8.done;
   assign obsOvf    = dutSel ? bus10.overflow   : bus8.overflow;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Scramble the request inputs; the DUT must only use values latched with start.
   task automatic scramble();
      runsDrv = 10'($urandom_range(0, 1023));
      wktDrv  = 4'($urandom_range(0, 15));
      ioDrv   = 1'($urandom_range(0, 1));
      goDrv   = 1'($urandom_range(0, 1));
      winDrv  = 1'($urandom_range(0, 1));
   endtask

   // One request, checked against a decimal model of the display contents.
   task automatic convert(input bit sel, input logic [9:0] r, input logic [3:0] w,
                          input logic io, input logic go, input logic win, input bit midStart);
      int unsigned rv, lat, cyc, busyCnt;
      logic [11:0] expDigits;
      logic [3:0]  expWkt;
      logic        expOvf;

      rv = sel ? int'(r) : (int'(r) & 255);
      if (go) begin
         expDigits = {4'hF, 4'h0, (win ? 4'h2 : 4'h1)};
         expWkt    = 4'h0;
         expOvf    = 1'b0;
         lat       = 1;
      end else if (io) begin
         expDigits = {4'hC, 4'hD, 4'h0};
         expWkt    = 4'hE;
         expOvf    = 1'b0;
         lat       = 1;
      end else begin
         lat    = (sel ? 10 : 8) + 1;
         expWkt = 4'(int'(w) % 10);
         if (rv > 999) begin
            expDigits = 12'h999;
            expOvf    = 1'b1;
         end else begin
            expDigits = 12'((rv / 100) * 256 + ((rv / 10) % 10) * 16 + (rv % 10));
            expOvf    = 1'b0;
         end
      end

      @(negedge clk);
      dutSel   = sel;
      resetN   = 1'b1;
      runsDrv  = 10'(rv);
      wktDrv   = w;
      ioDrv    = io;
      goDrv    = go;
      winDrv   = win;
      startDrv = 1'b1;
      @(posedge clk);
      #1;
      startDrv = 1'b0;
      scramble();

      cyc     = 0;
      busyCnt = 0;
      while (!obsDone && cyc < 40) begin
         if (obsBusy) busyCnt++;
         @(posedge clk);
         #1;
         cyc++;
         scramble();
         startDrv = midStart && (cyc == 2);
      end
      startDrv = 1'b0;

      checkVal("latency",  cyc,       lat);
      checkVal("busy_cyc", busyCnt,   lat);
      checkVal("digits",   obsDigits, expDigits);
      checkVal("wickets",  obsWkt,    expWkt);
      checkVal("overflow", obsOvf,    expOvf);
      checkVal("busy_end", obsBusy,   1'b0);

      @(posedge clk);
      #1;
      checkVal("done_pulse",  obsDone,   1'b0);
      checkVal("digits_hold", obsDigits, expDigits);
      checkVal("wkt_hold",    obsWkt,    expWkt);
   endtask

   initial begin
      bit doneSeen;

      resetN   = 1'b0;
      dutSel   = 1'b0;
      startDrv = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_digits8",  bus8.run_digits,  12'h0);
      checkVal("rst_wkt8",     bus8.wickets,     4'h0);
      checkVal("rst_busy8",    bus8.busy,        1'b0);
      checkVal("rst_done8",    bus8.done,        1'b0);
      checkVal("rst_ovf8",     bus8.overflow,    1'b0);
      checkVal("rst_digits10", bus10.run_digits, 12'h0);
      checkVal("rst_busy10",   bus10.busy,       1'b0);

      // Directed corner cases (start also lands on the first edge out of reset).
      convert(1'b0, 10'd255, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
      convert(1'b0, 10'd37,  4'd3,  1'b1, 1'b0, 1'b0, 1'b0);
      convert(1'b0, 10'd37,  4'd3,  1'b1, 1'b1, 1'b1, 1'b0);
      convert(1'b0, 10'd0,   4'd9,  1'b1, 1'b1, 1'b0, 1'b0);
      convert(1'b1, 10'd1000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      convert(1'b1, 10'd999,  4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      convert(1'b1, 10'd1023, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
      convert(1'b0, 10'd0,   4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
      convert(1'b0, 10'd128, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of SHIFT: conversion abandoned, no done.
      @(negedge clk);
      dutSel   = 1'b0;
      runsDrv  = 10'd200;
      wktDrv   = 4'd7;
      ioDrv    = 1'b0;
      goDrv    = 1'b0;
      startDrv = 1'b1;
      @(posedge clk);
      #1;
      startDrv = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      resetN = 1'b0;
      @(posedge clk);
      #1;
      checkVal("midrst_digits", bus8.run_digits, 12'h0);
      checkVal("midrst_wkt",    bus8.wickets,    4'h0);
      checkVal("midrst_busy",   bus8.busy,       1'b0);
      checkVal("midrst_done",   bus8.done,       1'b0);
      checkVal("midrst_ovf",    bus8.overflow,   1'b0);
      @(negedge clk);
      resetN   = 1'b1;
      doneSeen = 1'b0;
      repeat (14) begin
         @(posedge clk);
         #1;
         if (bus8.done) doneSeen = 1'b1;
      end
      checkVal("midrst_no_done", doneSeen,        1'b0);
      checkVal("midrst_idle",    bus8.busy,       1'b0);
      checkVal("midrst_keep0",   bus8.run_digits, 12'h0);
      @(negedge clk);
      resetN = 1'b0;
      convert(1'b0, 10'd249, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized requests across both instances.
      for (int i = 0; i < 40; i++) begin
         bit         s;
         logic [9:0] r;
         s = 1'($urandom_range(0, 1));
         if (s) begin
            r = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                            : 10'($urandom_range(0, 1023));
         end else begin
            r = 10'($urandom_range(0, 255));
         end
         convert(s, r, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/score_bcd_converter.md
SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of binary_runs (legal 4..16).
REQ-002 SHALL have parameter DIGITS, default 3, meaning number of displayed run digits (legal 3..5).
REQ-003 SHALL have parameter WKT_WIDTH, default 4, meaning bit width of binary_wickets (legal 1..7).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port start, input, 1, a request to convert; sampled only in IDLE.
REQ-007 SHALL have port binary_runs, input, WIDTH, the run total.
REQ-008 SHALL have port binary_wickets, input, WKT_WIDTH, the wicket count.
REQ-009 SHALL have port inning_over, input, 1, requesting the inning-over glyphs.
REQ-010 SHALL have port game_over, input, 1, requesting the winner glyphs.
REQ-011 SHALL have port winner, input, 1, where 0 means team 1 and 1 means team 2.
REQ-012 SHALL have port run_digits, output, 4*DIGITS, the digit codes; digit k is bits [4k+3:4k], and k=0 is the ones digit.
REQ-013 SHALL have port wickets, output, 4, the wicket digit code.
REQ-014 SHALL have port busy, output, 1, which is high while a conversion is in progress.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse marking that the outputs have been updated.
REQ-016 SHALL have port overflow, output, 1, which is high when the last result saturated.

Function
REQ-017 SHALL implement states IDLE, SHIFT and DONE; after reset the state is IDLE.
REQ-018 SHALL act on start=1 only in IDLE, latching runs, wickets, inning_over, game_over and winner on that edge; inputs are otherwise don't-care.
REQ-019 SHALL ignore start while busy=1, with no queuing and no restart.
REQ-020 SHALL give game_over priority over inning_over: if the latched game_over=1, go IDLE->DONE; else if the latched inning_over=1, go IDLE->DONE; else go IDLE->SHIFT.
REQ-021 SHALL, in SHIFT, perform one double-dabble iteration per cycle: add 3 to every BCD nibble >=5, then shift one binary bit in, MSB first.
REQ-022 SHALL leave SHIFT after exactly WIDTH iterations, using an iteration counter that counts down from WIDTH.
REQ-023 SHALL size the internal BCD scratch to ceil(WIDTH/3)+1 digits so the full value never truncates.
REQ-024 SHALL, in DONE, register all outputs, pulse done=1 for one cycle, then return to IDLE.
REQ-025 SHALL hold the outputs unchanged between DONE cycles.
REQ-026 SHALL set busy=1 in SHIFT and DONE, and busy=0 in IDLE.
REQ-027 SHALL have numeric-path latency such that, with start sampled at edge E, the outputs are valid and done=1 after edge E+WIDTH+1.
REQ-028 SHALL have glyph-path latency such that the outputs are valid and done=1 after edge E+1.
REQ-029 SHALL, on the numeric path, drive overflow=1 if runs > 10^DIGITS-1, and force every run_digits nibble to 4'h9.
REQ-030 SHALL, on the numeric path when runs <= 10^DIGITS-1, drive overflow=0 and take run_digits from the low DIGITS scratch digits.
REQ-031 SHALL, on the numeric path, drive wickets = latched binary_wickets mod 10.
REQ-032 SHALL produce the inning-over glyphs as follows: digit[DIGITS-1]=4'hC, digit[DIGITS-2]=4'hD, digit[0]=4'h0, all other digits=4'hA (blank), wickets=4'hE, overflow=0.
REQ-033 SHALL produce the winner glyphs as follows: digit[DIGITS-1]=4'hF, digit[DIGITS-2]=4'h0, digit[0]=(winner?4'h2:4'h1), all other digits=4'hA, wickets=4'h0, overflow=0.
REQ-034 SHALL keep the glyph codes consistent with the existing 7-segment decoder: C is an apostrophe, D is I, E is an apostrophe, F is t, and A is blank.

Reset
REQ-035 SHALL, while reset_n=0 at a rising edge, force: state=IDLE, run_digits=0, wickets=0, busy=0, done=0, overflow=0, iteration counter=0.
REQ-036 SHALL abandon any conversion in progress when reset is asserted mid-SHIFT, producing no done pulse.
REQ-037 SHALL sample start normally at the first edge with reset_n=1.

Verification
REQ-038 SHALL cover, with WIDTH=8 and DIGITS=3: runs=255, wickets=12, start -> after 9 edges run_digits=2,5,5, wickets=2, overflow=0, done pulsed once.
REQ-039 SHALL cover: inning_over=1, start -> after 1 edge run_digits=C,D,0, wickets=E, and busy is high for exactly 1 cycle.
REQ-040 SHALL cover: game_over=1, inning_over=1, winner=1, start -> run_digits=F,0,2 and wickets=0 (game_over wins).
REQ-041 SHALL cover, with DIGITS=3 and WIDTH=10: runs=1000 -> run_digits=9,9,9 and overflow=1; then runs=999 -> 9,9,9 with overflow=0.
REQ-042 SHALL cover: start pulsed mid-SHIFT with a different runs value -> the result reflects the first runs only, with a single done.
REQ-043 SHALL cover: reset_n low at SHIFT iteration 4 -> no done, all outputs 0; the next start converts correctly.
